// File: rtl/pxs_sprite_motion_sched_pkg.sv
// Shared types for the sprite motion scheduler: pixel-stream field positions,
// FSM state encoding, slot record layout and per-slot reset values.
package pxs_sprite_motion_sched_pkg;

  localparam int STR_W  = 26;
  localparam int CRD_W  = 10;
  localparam int XC_LSB = 16;
  localparam int YC_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BOUNCE  = 2'd1,
    ST_MOVE    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  // Bit order matches cfg_data so a write is a straight copy.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] sx;
    logic [2:0] sy;
    logic       dx;
    logic       dy;
  } cfg_t;

  typedef struct packed {
    cfg_t       mot;
    logic [1:0] idx;
  } slot_t;

  function automatic logic [CRD_W-1:0] str_xc(input logic [STR_W-1:0] s);
    return s[XC_LSB +: CRD_W];
  endfunction

  function automatic logic [CRD_W-1:0] str_yc(input logic [STR_W-1:0] s);
    return s[YC_LSB +: CRD_W];
  endfunction

  function automatic slot_t slot_reset(input int k);
    slot_t s;
    s.mot.x  = 10'(40 + 64 * k);
    s.mot.y  = '0;
    s.mot.sx = 3'd2;
    s.mot.sy = '0;
    s.mot.dx = 1'b0;
    s.mot.dy = 1'b0;
    s.idx    = '0;
    return s;
  endfunction

endpackage

// File: rtl/pxs_sprite_motion_sched_axis.sv
// One-axis step with wall bounce: advance pos by spd in direction dir, clamp at 0 / LIMIT.
// Purely combinational; no handshake.
module pxs_axis_step #(
  parameter int LIMIT = 608
) (
  input  logic [9:0] pos,
  input  logic [2:0] spd,
  input  logic       dir,
  output logic [9:0] pos_nxt,
  output logic       dir_nxt
);

  localparam logic [9:0] LIM = 10'(LIMIT);

  // 11-bit sum so x+sx near the top of the range cannot wrap below LIMIT.
  logic [10:0] fwd;
  assign fwd = {1'b0, pos} + {8'd0, spd};

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (!dir) begin
      if (fwd >= {1'b0, LIM}) begin
        pos_nxt = LIM;
        dir_nxt = 1'b1;
      end else begin
        pos_nxt = fwd[9:0];
      end
    end else begin
      if ({1'b0, pos} < {8'd0, spd}) begin
        pos_nxt = '0;
        dir_nxt = 1'b0;
      end else begin
        pos_nxt = pos - {7'd0, spd};
      end
    end
  end

endmodule

// File: rtl/pxs_sprite_motion_sched.sv
// Per-frame sprite motion: on end of frame, step/bounce each slot, apply gravity and animation on tick, publish.
// Latency: endframe at cycle T -> upd_done at T+2*N_SPRITE+1; cfg writes only accepted while idle (ignored, no ack, while busy).
module pxs_sprite_motion_sched
  import pxs_sprite_motion_sched_pkg::*;
#(
  parameter int N_SPRITE    = 4,
  parameter int VISIBLECOLS = 640,
  parameter int VISIBLEROWS = 480,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int ANIM_PERIOD = 10,
  parameter int MAX_SPEED   = 7
) (
  input  logic                          px_clk,
  input  logic                          px_rst,
  input  logic [STR_W-1:0]              RGBStr_i,
  input  logic                          cfg_we,
  input  logic [$clog2(N_SPRITE)-1:0]   cfg_sel,
  input  logic [27:0]                   cfg_data,
  output logic                          cfg_ack,
  output logic [N_SPRITE*10-1:0]        spr_x,
  output logic [N_SPRITE*10-1:0]        spr_y,
  output logic [N_SPRITE*2-1:0]         spr_idx,
  output logic                          busy,
  output logic                          upd_done
);

  localparam int                SEL_W    = $clog2(N_SPRITE);
  localparam int                CNT_W    = $clog2(ANIM_PERIOD + 1);
  localparam logic [CNT_W-1:0]  TICK_CNT = CNT_W'(ANIM_PERIOD - 1);
  localparam logic [SEL_W-1:0]  K_LAST   = SEL_W'(N_SPRITE - 1);
  localparam logic [2:0]        SY_MAX   = 3'(MAX_SPEED);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  k;
  logic [CNT_W-1:0]  frame_cnt;
  slot_t             wrk [N_SPRITE];
  slot_t             pub [N_SPRITE];
  slot_t             cur, mv;
  cfg_t              cfg_in;
  logic [9:0]        stg_x, stg_y, step_x, step_y;
  logic              stg_dx, stg_dy, step_dx, step_dy;
  logic              endframe, tick, cfg_accept, str_unused;

  assign cfg_in     = cfg_data;
  assign cur        = wrk[k];
  assign tick       = (frame_cnt == TICK_CNT);
  assign endframe   = (str_xc(RGBStr_i) == 10'(VISIBLECOLS - 1)) &&
                      (str_yc(RGBStr_i) == 10'(VISIBLEROWS - 1));
  assign str_unused = ^RGBStr_i[YC_LSB-1:0];

  pxs_axis_step #(.LIMIT(VISIBLECOLS - SPRITE_W)) u_step_x (
    .pos     (cur.mot.x),
    .spd     (cur.mot.sx),
    .dir     (cur.mot.dx),
    .pos_nxt (step_x),
    .dir_nxt (step_dx)
  );

  pxs_axis_step #(.LIMIT(VISIBLEROWS - SPRITE_H)) u_step_y (
    .pos     (cur.mot.y),
    .spd     (cur.mot.sy),
    .dir     (cur.mot.dy),
    .pos_nxt (step_y),
    .dir_nxt (step_dy)
  );

  // Gravity and animation act on the post-bounce direction bits.
  always_comb begin
    mv        = cur;
    mv.mot.x  = stg_x;
    mv.mot.dx = stg_dx;
    mv.mot.y  = stg_y;
    mv.mot.dy = stg_dy;
    if (tick) begin
      if (stg_dy) begin
        if (cur.mot.sy <= 3'd1) begin
          mv.mot.sy = '0;
          mv.mot.dy = 1'b0;
        end else begin
          mv.mot.sy = cur.mot.sy - 3'd1;
        end
      end else if (cur.mot.sy < SY_MAX) begin
        mv.mot.sy = cur.mot.sy + 3'd1;
      end
      mv.idx = stg_dx ? cur.idx - 2'd1 : cur.idx + 2'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != ST_IDLE);
    upd_done   = (state == ST_PUBLISH);
    cfg_accept = (state == ST_IDLE) && cfg_we;
    case (state)
      ST_IDLE:    if (endframe) state_nxt = ST_BOUNCE;
      ST_BOUNCE:  state_nxt = ST_MOVE;
      ST_MOVE:    state_nxt = (k == K_LAST) ? ST_PUBLISH : ST_BOUNCE;
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // During PUBLISH the outputs already show the new set, so upd_done and data align.
  always_comb begin
    spr_x   = '0;
    spr_y   = '0;
    spr_idx = '0;
    for (int i = 0; i < N_SPRITE; i++) begin
      spr_x[10*i +: 10]  = upd_done ? wrk[i].mot.x : pub[i].mot.x;
      spr_y[10*i +: 10]  = upd_done ? wrk[i].mot.y : pub[i].mot.y;
      spr_idx[2*i +: 2]  = upd_done ? wrk[i].idx   : pub[i].idx;
    end
  end

  always_ff @(posedge px_clk) begin
    if (px_rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      frame_cnt <= '0;
      cfg_ack   <= 1'b0;
      stg_x     <= '0;
      stg_y     <= '0;
      stg_dx    <= 1'b0;
      stg_dy    <= 1'b0;
      for (int i = 0; i < N_SPRITE; i++) begin
        wrk[i] <= slot_reset(i);
        pub[i] <= slot_reset(i);
      end
    end else begin
      state   <= state_nxt;
      cfg_ack <= cfg_accept;
      if (cfg_accept) begin
        wrk[cfg_sel].mot <= cfg_in;
      end
      case (state)
        ST_IDLE: k <= '0;
        ST_BOUNCE: begin
          stg_x  <= step_x;
          stg_dx <= step_dx;
          stg_y  <= step_y;
          stg_dy <= step_dy;
        end
        ST_MOVE: begin
          wrk[k] <= mv;
          k      <= k + SEL_W'(1);
        end
        ST_PUBLISH: begin
          for (int i = 0; i < N_SPRITE; i++) begin
            pub[i] <= wrk[i];
          end
          frame_cnt <= tick ? '0 : frame_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pxs_sprite_motion_sched.sv
// Directed bench with a frame-level motion model and per-cycle output comparison.
module tb_pxs_sprite_motion_sched;

  localparam int N    = 4;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int SW   = 32;
  localparam int SH   = 32;
  localparam int AP   = 10;
  localparam int MS   = 7;
  localparam int XMAX = COLS - SW;
  localparam int YMAX = ROWS - SH;

  logic             px_clk = 1'b0;
  logic             px_rst;
  logic [25:0]      rgb;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [27:0]      cfg_data;
  logic             cfg_ack;
  logic [N*10-1:0]  spr_x, spr_y;
  logic [N*2-1:0]   spr_idx;
  logic             busy, upd_done;

  always #5 px_clk = ~px_clk;

  pxs_sprite_motion_sched #(
    .N_SPRITE(N), .VISIBLECOLS(COLS), .VISIBLEROWS(ROWS), .SPRITE_W(SW),
    .SPRITE_H(SH), .ANIM_PERIOD(AP), .MAX_SPEED(MS)
  ) dut (
    .px_clk(px_clk), .px_rst(px_rst), .RGBStr_i(rgb), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_ack(cfg_ack), .spr_x(spr_x),
    .spr_y(spr_y), .spr_idx(spr_idx), .busy(busy), .upd_done(upd_done)
  );

  int errs = 0;
  int checks = 0;
  int m_x[N], m_y[N], m_sx[N], m_sy[N], m_dx[N], m_dy[N], m_idx[N];
  int p_x[N], p_y[N], p_idx[N];
  int m_cnt;
  bit exp_busy, exp_done, exp_ack, ack_next, chk_en;

  function automatic logic [27:0] mk_cfg(input int x, input int y, input int sx,
                                         input int sy, input int dx, input int dy);
    return {10'(x), 10'(y), 3'(sx), 3'(sy), 1'(dx), 1'(dy)};
  endfunction

  function automatic void model_publish();
    for (int k = 0; k < N; k++) begin
      p_x[k] = m_x[k]; p_y[k] = m_y[k]; p_idx[k] = m_idx[k];
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_x[k] = 40 + 64 * k; m_y[k] = 0; m_sx[k] = 2; m_sy[k] = 0;
      m_dx[k] = 0; m_dy[k] = 0; m_idx[k] = 0;
    end
    m_cnt = 0;
    model_publish();
  endfunction

  function automatic void model_cfg(input int sel, input logic [27:0] d);
    m_x[sel] = int'(d[27:18]); m_y[sel] = int'(d[17:8]);
    m_sx[sel] = int'(d[7:5]); m_sy[sel] = int'(d[4:2]);
    m_dx[sel] = int'(d[1]);   m_dy[sel] = int'(d[0]);
  endfunction

  function automatic void step_axis(input int pos, input int spd, input int dir, input int lim,
                                    output int np, output int nd);
    np = pos; nd = dir;
    if (dir == 0) begin
      if (pos + spd >= lim) begin np = lim; nd = 1; end
      else np = pos + spd;
    end else begin
      if (pos < spd) begin np = 0; nd = 0; end
      else np = pos - spd;
    end
  endfunction

  function automatic void model_run();
    bit tk;
    int np, nd;
    tk = (m_cnt == AP - 1);
    for (int k = 0; k < N; k++) begin
      step_axis(m_x[k], m_sx[k], m_dx[k], XMAX, np, nd); m_x[k] = np; m_dx[k] = nd;
      step_axis(m_y[k], m_sy[k], m_dy[k], YMAX, np, nd); m_y[k] = np; m_dy[k] = nd;
      if (tk) begin
        if (m_dy[k] == 1) begin
          m_sy[k] = (m_sy[k] > 0) ? m_sy[k] - 1 : 0;
          if (m_sy[k] == 0) m_dy[k] = 0;
        end else if (m_sy[k] < MS) begin
          m_sy[k] = m_sy[k] + 1;
        end
        m_idx[k] = (m_idx[k] + ((m_dx[k] == 1) ? 3 : 1)) % 4;
      end
    end
    m_cnt = tk ? 0 : m_cnt + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    if (chk_en) begin
      check("busy", 32'(busy), int'(exp_busy));
      check("upd_done", 32'(upd_done), int'(exp_done));
      check("cfg_ack", 32'(cfg_ack), int'(exp_ack));
      for (int k = 0; k < N; k++) begin
        check($sformatf("spr_x[%0d]", k), 32'(spr_x[10*k +: 10]), p_x[k]);
        check($sformatf("spr_y[%0d]", k), 32'(spr_y[10*k +: 10]), p_y[k]);
        check($sformatf("spr_idx[%0d]", k), 32'(spr_idx[2*k +: 2]), p_idx[k]);
      end
    end
  endtask

  // Compare at negedge, then move to just after the next rising edge with idle defaults.
  task automatic cyc();
    @(negedge px_clk);
    compare_cycle();
    @(posedge px_clk);
    #1;
    exp_ack  = ack_next;
    ack_next = 1'b0;
    cfg_we   = 1'b0;
    rgb      = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic idle_near();
    rgb = {10'(COLS - 1), 10'(ROWS - 2), 6'd0};
    cyc();
    rgb = {10'(COLS - 2), 10'(ROWS - 1), 6'd0};
    cyc();
    cyc();
  endtask

  task automatic cfg_write(input int sel, input logic [27:0] d);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_data = d;
    model_cfg(sel, d);
    ack_next = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic sync_reset();
    px_rst = 1'b1;
    cyc();
    model_reset();
    px_rst = 1'b0;
    cyc();
  endtask

  task automatic run_frame(input bit coinc, input bit busy_cfg, input bit rst_mid,
                           input int sel, input logic [27:0] d);
    rgb = {10'(COLS - 1), 10'(ROWS - 1), 6'd0};
    if (coinc) begin
      cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_data = d;
      model_cfg(sel, d);
      ack_next = 1'b1;
    end
    model_run();
    cyc();
    for (int c = 1; c <= 2 * N + 1; c++) begin
      exp_busy = 1'b1;
      exp_done = (c == 2 * N + 1);
      if (c == 2 * N + 1) model_publish();
      if (busy_cfg && c == 3) begin
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_data = d;
      end
      if (rst_mid && c == 4) begin
        px_rst = 1'b1;
        cyc();
        px_rst = 1'b0;
        model_reset();
        return;
      end
      cyc();
    end
    cyc();
  endtask

  initial begin
    px_rst = 1'b1; rgb = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    chk_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_ack = 1'b0; ack_next = 1'b0;
    model_reset();
    cyc();
    chk_en = 1'b1;
    cyc();
    px_rst = 1'b0;
    cyc();
    check("reset spr_x0", 32'(spr_x[9:0]), 40);
    check("reset spr_x3", 32'(spr_x[39:30]), 232);
    check("reset spr_y0", 32'(spr_y[9:0]), 0);
    idle_near();

    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("run1 spr_x0", 32'(spr_x[9:0]), 42);
    check("run1 spr_y0", 32'(spr_y[9:0]), 0);

    cfg_write(1, mk_cfg(607, 100, 3, 0, 0, 0));
    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("right wall clamp", 32'(spr_x[19:10]), 608);
    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("right wall reverse", 32'(spr_x[19:10]), 605);

    cfg_write(2, mk_cfg(300, 446, 0, 5, 0, 0));
    cfg_write(1, mk_cfg(1, 0, 3, 0, 1, 0));
    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("floor clamp", 32'(spr_y[29:20]), 448);
    check("left wall clamp", 32'(spr_x[19:10]), 0);
    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("floor reverse", 32'(spr_y[29:20]), 443);
    check("left wall reverse", 32'(spr_x[19:10]), 3);

    sync_reset();
    cfg_write(3, mk_cfg(300, 100, 0, 1, 0, 1));
    for (int r = 1; r <= 11; r++) begin
      run_frame(1'b0, 1'b0, 1'b0, 0, '0);
      if (r == 9) begin
        check("gravity run9 y", 32'(spr_y[39:30]), 91);
        check("gravity run9 idx", 32'(spr_idx[7:6]), 0);
      end
      if (r == 10) begin
        check("gravity tick y", 32'(spr_y[39:30]), 90);
        check("gravity tick idx", 32'(spr_idx[7:6]), 1);
      end
      if (r == 11) check("stationary after tick", 32'(spr_y[39:30]), 90);
    end

    run_frame(1'b0, 1'b1, 1'b0, 0, mk_cfg(500, 0, 2, 0, 0, 0));
    check("busy cfg ignored", 32'(spr_x[9:0]), 64);
    idle_near();

    run_frame(1'b1, 1'b0, 1'b0, 0, mk_cfg(200, 0, 2, 0, 0, 0));
    check("coincident cfg used", 32'(spr_x[9:0]), 202);

    run_frame(1'b0, 1'b0, 1'b1, 0, '0);
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    check("abort spr_x0", 32'(spr_x[9:0]), 40);
    check("abort spr_x1", 32'(spr_x[19:10]), 104);
    check("abort busy", 32'(busy), 0);

    run_frame(1'b0, 1'b0, 1'b0, 0, '0);
    check("post-abort spr_x0", 32'(spr_x[9:0]), 42);
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
